async_fifo_wr_ctrl: RTL and testbench
=====================================

# async_fifo_wr_ctrl

Write-side pointer and flag controller for the async FIFO, in the write clock domain. It accepts push requests and drives the RAM write enable and address. It launches a registered Gray-coded write pointer toward the read domain through `async_fifo_flop_sync`. It generates `full` and `almost_full` from the read pointer after that pointer has been synchronized back into this domain.

## Interface

Parameters:
- `ADDR_W`, default 4: RAM address width; depth = 2^ADDR_W; legal range ≥ 2.
- `AFULL_THRESH`, default 2: `almost_full` asserts when free slots ≤ this value; legal range 1 to 2^ADDR_W−1.

Ports:
- `clk` input 1: write-domain clock. The block has one clock; all logic is on its rising edge.
- `reset_n` input 1: reset, asynchronous and active-low.
- `wr_en` input 1: push request, one entry per cycle.
- `rd_ptr_gray_sync` input ADDR_W+1: read Gray pointer, already synchronized into `clk` domain.
- `mem_we` output 1: RAM write strobe, combinational.
- `wr_addr` output ADDR_W: RAM write address.
- `wr_ptr_gray` output ADDR_W+1: registered Gray write pointer, sent to the read-domain synchronizer.
- `full` output 1: registered; no push is accepted while high.
- `almost_full` output 1: registered threshold flag.
- `wr_count` output ADDR_W+1: registered fill level as seen from the write side.
- `overflow` output 1: push attempted while full (see Configuration).

## Operation

- Internal binary pointer `wr_bin` [ADDR_W:0]. `wr_addr = wr_bin[ADDR_W-1:0]`.
- `accept = wr_en & ~full`. `mem_we = accept`. `wr_en` while `full` is dropped: no write, no pointer change.
- Next pointer: `wr_bin_nxt = wr_bin + accept`, modulo 2^(ADDR_W+1). `wr_gray_nxt = wr_bin_nxt ^ (wr_bin_nxt >> 1)`.
- Per clock:
  - `wr_bin <= wr_bin_nxt`
  - `wr_ptr_gray <= wr_gray_nxt`
- Full compare:
  - `full <= (wr_gray_nxt == {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]})`.
- Fill level:
  - `rd_bin` = Gray-to-binary of `rd_ptr_gray_sync` (XOR prefix from the MSB).
  - `wr_count <= wr_bin_nxt - rd_bin`, modulo 2^(ADDR_W+1).
  - `almost_full <= (wr_count_nxt >= 2^ADDR_W - AFULL_THRESH)`, where `wr_count_nxt` is the value being loaded into `wr_count`.
- The read pointer is stale by the synchronizer latency. Flags and count are therefore pessimistic: they may over-report fill, and never under-report it. This is the required behaviour.
- `wr_ptr_gray` must come straight from a flop, with no logic after it. Exactly one bit changes per accepted push.

## Timing

- Reset values: `wr_bin`, `wr_addr`, `wr_ptr_gray`, `wr_count` = 0; `full`, `almost_full`, `overflow` = 0. `mem_we` = 0 while in reset.
- Write latency: the RAM writes `wr_addr` in the same cycle `mem_we` is high. `wr_ptr_gray` advances on the following edge.
- The push that fills the FIFO raises `full` on that same edge. The next cycle's `wr_en` is refused.
- Release: a change on `rd_ptr_gray_sync` that frees a slot drops `full` one edge later.
- Simultaneous push and read-pointer advance in one cycle: both take effect in the `full`/`wr_count` update. The count stays unchanged when one push and one freed slot coincide.
- Wrap-around: `wr_bin` rolls from 2^(ADDR_W+1)−1 to 0. The full compare relies on that extra MSB.
- Reset mid-operation: all state returns to reset values immediately. Entries already in the RAM are abandoned. The read side must be reset in the same reset window.

## Configuration

- Macro `ASYNC_FIFO_WR_OVF_EN`.
- Defined: `overflow` is a sticky flop. It sets on the edge after any cycle with `wr_en & full`, and clears only on reset.
- Not defined: `overflow` is tied to 0 and no flop is inferred.
- Push blocking while `full` is identical in both builds.

## Test plan

All scenarios use ADDR_W=4 (depth 16) and AFULL_THRESH=2.

1. Reset:
   - Stimulus: hold `reset_n`=0 with `wr_en`=1 toggling.
   - Response: all outputs 0 and `mem_we`=0.
   - After release, the first push writes `wr_addr`=0, and `wr_ptr_gray` becomes 5'b00001.
2. Fill, refused push and overflow:
   - Stimulus: `rd_ptr_gray_sync`=0, then 16 consecutive pushes.
   - Response: `almost_full` rises after push 14, and `full` rises after push 16. At that point `wr_ptr_gray`=5'b11000 and `wr_count`=16.
   - Stimulus: a 17th push.
   - Response: `mem_we`=0, the pointer is unchanged, and `overflow`=1 if the macro is defined (0 otherwise).
3. Drain:
   - Stimulus: from the full state, set `rd_ptr_gray_sync`=5'b00110 (binary 4).
   - Response: one edge later `full`=0, `almost_full`=0, `wr_count`=12.
4. Wrap-around:
   - Stimulus: 40 pushes with the read pointer tracking 2 behind.
   - Response: `full` never asserts, and `wr_addr` follows 0..15,0..15,0..7.
   - At push 32, `wr_bin` rolls to 0 and `wr_ptr_gray`=5'b00000.
5. Simultaneous events:
   - Stimulus: at `wr_count`=15, push while `rd_ptr_gray_sync` advances by one.
   - Response: the push is accepted, `wr_count` stays 15, and `full` stays 0.
6. Reset mid-fill:
   - Stimulus: assert `reset_n`=0 after 9 pushes.
   - Response: outputs clear asynchronously without waiting for a clock edge, and the next push after release writes address 0.

Source files
------------

// File: rtl/async_fifo_wr_ctrl.sv
// Write-domain pointer/flag controller for the async FIFO: RAM write strobe, Gray write pointer, full/almost_full, fill level.
// Optional sticky overflow flag enabled by defining ASYNC_FIFO_WR_OVF_EN.
module async_fifo_wr_ctrl #(
  parameter int unsigned ADDR_W       = 4,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   rd_ptr_gray_sync,
  output logic              mem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W:0]   wr_ptr_gray,
  output logic              full,
  output logic              almost_full,
  output logic [ADDR_W:0]   wr_count,
  output logic              overflow
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [PTR_W-1:0] AFULL_LVL = PTR_W'(DEPTH - AFULL_THRESH);

  logic [PTR_W-1:0] wr_bin_q,   wr_bin_d;
  logic [PTR_W-1:0] wr_gray_q,  wr_gray_d;
  logic [PTR_W-1:0] wr_count_q, wr_count_d;
  logic             full_q,     full_d;
  logic             afull_q,    afull_d;
  logic             accept_c;
  logic [PTR_W-1:0] rd_bin_c;
  logic [PTR_W-1:0] rd_full_cmp_c;

  // Accept logic and next-state pointers; strobe is held low while in reset
  always_comb begin
    accept_c      = wr_en & ~full_q & reset_n;
    wr_bin_d      = wr_bin_q + PTR_W'(accept_c);
    wr_gray_d     = wr_bin_d ^ (wr_bin_d >> 1);
    rd_bin_c      = '0;
    for (int unsigned i = 0; i < PTR_W; i++) begin
      rd_bin_c[i] = ^(rd_ptr_gray_sync >> i);
    end
    // Full when the write pointer leads the read pointer by exactly one lap
    rd_full_cmp_c = {~rd_ptr_gray_sync[ADDR_W:ADDR_W-1], rd_ptr_gray_sync[ADDR_W-2:0]};
    full_d        = (wr_gray_d == rd_full_cmp_c);
    wr_count_d    = wr_bin_d - rd_bin_c;
    afull_d       = (wr_count_d >= AFULL_LVL);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_bin_q   <= '0;
      wr_gray_q  <= '0;
      wr_count_q <= '0;
      full_q     <= 1'b0;
      afull_q    <= 1'b0;
    end else begin
      wr_bin_q   <= wr_bin_d;
      wr_gray_q  <= wr_gray_d;
      wr_count_q <= wr_count_d;
      full_q     <= full_d;
      afull_q    <= afull_d;
    end
  end

  assign mem_we      = accept_c;
  assign wr_addr     = wr_bin_q[ADDR_W-1:0];
  assign wr_ptr_gray = wr_gray_q;
  assign full        = full_q;
  assign almost_full = afull_q;
  assign wr_count    = wr_count_q;

`ifdef ASYNC_FIFO_WR_OVF_EN
  logic overflow_q, overflow_d;

  // Sticky: any refused push sets it until reset
  always_comb begin
    overflow_d = overflow_q | (wr_en & full_q);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_async_fifo_wr_ctrl.sv
// Directed self-checking bench for async_fifo_wr_ctrl at ADDR_W=4, AFULL_THRESH=2.
module tb_async_fifo_wr_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr_en;
  logic [4:0] rd_ptr_gray_sync;
  logic       mem_we;
  logic [3:0] wr_addr;
  logic [4:0] wr_ptr_gray;
  logic       full;
  logic       almost_full;
  logic [4:0] wr_count;
  logic       overflow;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ASYNC_FIFO_WR_OVF_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  async_fifo_wr_ctrl #(.ADDR_W(4), .AFULL_THRESH(2)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .wr_en            (wr_en),
    .rd_ptr_gray_sync (rd_ptr_gray_sync),
    .mem_we           (mem_we),
    .wr_addr          (wr_addr),
    .wr_ptr_gray      (wr_ptr_gray),
    .full             (full),
    .almost_full      (almost_full),
    .wr_count         (wr_count),
    .overflow         (overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] gray(input int b);
    logic [4:0] v;
    v = 5'(b);
    return v ^ (v >> 1);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".mem_we"},      32'(mem_we),      32'd0);
    chk({tag, ".wr_addr"},     32'(wr_addr),     32'd0);
    chk({tag, ".wr_ptr_gray"}, 32'(wr_ptr_gray), 32'd0);
    chk({tag, ".full"},        32'(full),        32'd0);
    chk({tag, ".almost_full"}, 32'(almost_full), 32'd0);
    chk({tag, ".wr_count"},    32'(wr_count),    32'd0);
    chk({tag, ".overflow"},    32'(overflow),    32'd0);
  endtask

  initial begin
    int wb;
    int rb;
    reset_n          = 1'b0;
    wr_en            = 1'b0;
    rd_ptr_gray_sync = 5'd0;

    // 1. Reset held with wr_en toggling
    for (int i = 0; i < 4; i++) begin
      tick();
      wr_en = ~wr_en;
      #1;
      chk("rst_hold", 32'(mem_we), 32'd0);
    end
    wr_en = 1'b1;
    #1;
    chk_zero("rst");
    tick();
    reset_n = 1'b1;
    wr_en   = 1'b1;
    #1;
    chk("first_push.mem_we", 32'(mem_we), 32'd1);
    chk("first_push.wr_addr", 32'(wr_addr), 32'd0);
    tick();
    chk("first_push.gray", 32'(wr_ptr_gray), 32'h01);
    chk("first_push.count", 32'(wr_count), 32'd1);

    // 2. Fill to 16
    for (int n = 2; n <= 16; n++) begin
      tick();
      if (n == 13) chk("fill13.afull", 32'(almost_full), 32'd0);
      if (n == 14) chk("fill14.afull", 32'(almost_full), 32'd1);
      if (n == 15) chk("fill15.full", 32'(full), 32'd0);
    end
    chk("fill16.full", 32'(full), 32'd1);
    chk("fill16.gray", 32'(wr_ptr_gray), 32'h18);
    chk("fill16.count", 32'(wr_count), 32'd16);
    chk("fill16.ovf", 32'(overflow), 32'd0);
    // 17th push is refused
    #1;
    chk("push17.mem_we", 32'(mem_we), 32'd0);
    tick();
    wr_en = 1'b0;
    chk("push17.gray", 32'(wr_ptr_gray), 32'h18);
    chk("push17.ovf", 32'(overflow), 32'(OVF_EXP));
    chk("push17.full", 32'(full), 32'd1);

    // 3. Drain: read pointer jumps to 4
    rd_ptr_gray_sync = 5'b00110;
    tick();
    chk("drain.full", 32'(full), 32'd0);
    chk("drain.afull", 32'(almost_full), 32'd0);
    chk("drain.count", 32'(wr_count), 32'd12);

    // 4. Wrap-around: 40 pushes with reader 2 behind
    reset_n = 1'b0;
    rd_ptr_gray_sync = 5'd0;
    #2;
    chk_zero("rst2");
    reset_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      wb = k - 1;
      rb = (wb >= 2) ? wb - 2 : 0;
      rd_ptr_gray_sync = gray(rb);
      wr_en = 1'b1;
      #1;
      chk("wrap.wr_addr", 32'(wr_addr), 32'(wb % 16));
      tick();
      chk("wrap.full", 32'(full), 32'd0);
      if (k == 32) chk("wrap32.gray", 32'(wr_ptr_gray), 32'h00);
    end
    chk("wrap40.count", 32'(wr_count), 32'd3);
    chk("wrap40.gray", 32'(wr_ptr_gray), 32'(gray(8)));

    // 5. Raise count to 15 with reader at 5, then push while reader advances
    for (int k = 0; k < 12; k++) tick();
    chk("pre_sim.count", 32'(wr_count), 32'd15);
    chk("pre_sim.full", 32'(full), 32'd0);
    chk("pre_sim.afull", 32'(almost_full), 32'd1);
    rd_ptr_gray_sync = gray(6);
    #1;
    chk("sim.mem_we", 32'(mem_we), 32'd1);
    tick();
    wr_en = 1'b0;
    chk("sim.count", 32'(wr_count), 32'd15);
    chk("sim.full", 32'(full), 32'd0);
    chk("sim.gray", 32'(wr_ptr_gray), 32'h1F);

    // 6. Reset mid-fill after 9 pushes
    reset_n = 1'b0;
    rd_ptr_gray_sync = 5'd0;
    #2;
    reset_n = 1'b1;
    wr_en = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    chk("mid.count", 32'(wr_count), 32'd9);
    chk("mid.gray", 32'(wr_ptr_gray), 32'h0D);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    tick();
    reset_n = 1'b1;
    #1;
    chk("post_rst.mem_we", 32'(mem_we), 32'd1);
    chk("post_rst.wr_addr", 32'(wr_addr), 32'd0);
    tick();
    wr_en = 1'b0;
    chk("post_rst.gray", 32'(wr_ptr_gray), 32'h01);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
